fixed_point_alu: RTL

//   Parametrised signed fixed-point ALU, Q(WIDTH-FRAC).FRAC in and out.

---
 rtl/fixed_point_alu_if.sv | 24 ++
 rtl/fixed_point_alu.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fixed_point_alu_if.sv
// Operand/result handshake bundle for the fixed-point ALU.
// The master drives operands and out_ready; the slave (the ALU) drives results.
interface fixed_point_alu_if #(parameter int WIDTH = 8);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, div_by_zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, overflow, div_by_zero
    );
endinterface

// File: rtl/fixed_point_alu.sv
// Signed Q(WIDTH-FRAC).FRAC ALU: add/sub/mul in one cycle, restoring divide
// over WIDTH+FRAC cycles; all results saturated with overflow/div-by-zero flags.
module fixed_point_alu #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 3
) (
    input logic              clk,
    input logic              rst_n,
    fixed_point_alu_if.slave bus
);
    localparam int N  = WIDTH + FRAC;
    localparam int XW = 2 * WIDTH + FRAC + 2;
    localparam int CW = $clog2(N + 1);

    localparam logic signed [XW-1:0] SMAX_X = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN_X = ~SMAX_X;
    localparam logic [WIDTH-1:0]     SMAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     SMIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic signed [XW-1:0] ax, bx, prod, qx;
    logic [WIDTH:0]       sat;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_sub;
    logic                 qbit;
    logic [N-1:0]         q_full;
    logic                 last_iter;

    // Returns {overflow, value}; overflow set only when clamping changed v.
    function automatic logic [WIDTH:0] saturate(input logic signed [XW-1:0] v);
        if (v > SMAX_X)      saturate = {1'b1, SMAX};
        else if (v < SMIN_X) saturate = {1'b1, SMIN};
        else                 saturate = {1'b0, v[WIDTH-1:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = (bus.op == 2'b11) ? DIV : DONE;
            DIV:     if (last_iter) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
    end

    assign bus.result      = result_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_q;

    always_comb begin
        a_d      = a_q;
        neg_d    = neg_q;
        dsr_d    = dsr_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        sat      = '0;
        qx       = '0;

        ax    = $signed(bus.a);
        bx    = $signed(bus.b);
        prod  = (ax * bx) >>> FRAC;
        abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
        abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;

        // One restoring step: dividend bits shift out of dvd, quotient bits shift in.
        rem_sh    = {rem_q, dvd_q[N-1]};
        qbit      = (rem_sh >= {1'b0, dsr_q});
        rem_sub   = rem_sh[WIDTH-1:0] - dsr_q;
        q_full    = {dvd_q[N-2:0], qbit};
        last_iter = (cnt_q == CW'(N - 1));

        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d      = bus.a;
                neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                dsr_d    = abs_b;
                dvd_d    = N'(abs_a) << FRAC;
                rem_d    = '0;
                cnt_d    = '0;
                result_d = '0;
                ovf_d    = 1'b0;
                dbz_d    = 1'b0;
                case (bus.op)
                    2'b00:   sat = saturate(ax + bx);
                    2'b01:   sat = saturate(ax - bx);
                    2'b10:   sat = saturate(prod);
                    default: sat = '0;
                endcase
                if (bus.op != 2'b11) begin
                    result_d = sat[WIDTH-1:0];
                    ovf_d    = sat[WIDTH];
                end
            end
            DIV: begin
                rem_d = qbit ? rem_sub : rem_sh[WIDTH-1:0];
                dvd_d = q_full;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    qx = XW'(q_full);
                    if (neg_q) qx = -qx;
                    if (dsr_q == '0) begin
                        dbz_d    = 1'b1;
                        ovf_d    = 1'b0;
                        result_d = (a_q == '0) ? '0 : (a_q[WIDTH-1] ? SMIN : SMAX);
                    end else begin
                        sat      = saturate(qx);
                        result_d = sat[WIDTH-1:0];
                        ovf_d    = sat[WIDTH];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            neg_q    <= 1'b0;
            dsr_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            a_q      <= a_d;
            neg_q    <= neg_d;
            dsr_q    <= dsr_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
        end
    end
endmodule
